// File: rtl/mult_seq_pkg.sv
// mult_seq_pkg: shared FSM state type and default widths for the sequential multiplier
package mult_seq_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam int M_DEF = 4;
    localparam int N_DEF = 4;
endpackage

// File: rtl/rca_nbit.sv
// rca_nbit: W-bit ripple-carry adder with carry in and carry out
module rca_nbit #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] s,
    output logic         co
);
    logic [W:0] c;
    assign c[0] = cin;
    for (genvar i = 0; i < W; i++) begin : g_bit
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    assign co = c[W];
endmodule

// File: rtl/mult_seq_ctrl.sv
// mult_seq_ctrl: shift-add sequential multiplier, one adder, N RUN cycles; MULT_SEQ_ZERO_SKIP_EN finishes zero operands at once
module mult_seq_ctrl
    import mult_seq_pkg::*;
#(
    parameter int M = M_DEF,
    parameter int N = N_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [M-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           ready,
    output logic           busy,
    output logic           done,
    output logic [M+N-1:0] prod
);
    localparam int CW = $clog2(N + 1);
    state_t         state, state_nxt;
    logic [M-1:0]   a_reg, addend, sum;
    logic [N-1:0]   b_reg;
    logic [M+N-1:0] acc, acc_nxt;
    logic [CW-1:0]  cnt;
    logic           co, accept, last, zero;
    assign addend  = {M{b_reg[0]}} & a_reg;
    rca_nbit #(.W(M)) u_rca (
        .a  (acc[M+N-1:N]),
        .b  (addend),
        .cin(1'b0),
        .s  (sum),
        .co (co)
    );
    assign acc_nxt = {co, sum, acc[N-1:1]};
    assign last    = cnt == CW'(N - 1);
`ifdef MULT_SEQ_ZERO_SKIP_EN
    assign zero = (a == '0) || (b == '0);
`else
    assign zero = 1'b0;
`endif
    // status decode and next state; DONE falls back to IDLE unless a new start is taken
    always_comb begin
        ready     = state != RUN;
        busy      = state == RUN;
        done      = state == DONE;
        accept    = start && ready;
        state_nxt = accept ? (zero ? DONE : RUN) : (state == RUN) ? (last ? DONE : RUN) : IDLE;
    end
    // state register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end
    // operand capture, one shift-add step per RUN cycle, product load on DONE entry
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_reg <= '0;
            b_reg <= '0;
            acc   <= '0;
            cnt   <= '0;
            prod  <= '0;
        end else if (accept) begin
            a_reg <= a;
            b_reg <= b;
            acc   <= '0;
            cnt   <= '0;
            if (zero) prod <= '0;
        end else if (state == RUN) begin
            acc   <= acc_nxt;
            b_reg <= {acc[0], b_reg[N-1:1]};
            cnt   <= cnt + 1'b1;
            if (last) prod <= acc_nxt;
        end
    end
endmodule

// File: doc/mult_seq_ctrl.md
MULT_SEQ_CTRL -- requirements
Module: mult_seq_ctrl

Interface
REQ-001 The module SHALL take parameter M, default 4, as the multiplicand width (M >= 2).
REQ-002 The module SHALL take parameter N, default 4, as the multiplier width and iteration count (N >= 2).
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  reset; synchronous, active-low.
REQ-005 start  input  1  request to begin a multiply; sampled only while ready=1.
REQ-006 a  input  M  unsigned multiplicand; captured on an accepted start.
REQ-007 b  input  N  unsigned multiplier; captured on an accepted start.
REQ-008 ready  output  1  high only in IDLE and DONE; a new operation may be accepted.
REQ-009 busy  output  1  high only in RUN.
REQ-010 done  output  1  single-cycle pulse, high only in DONE.
REQ-011 prod  output  M+N  unsigned product a*b; registered output.

Function
REQ-012 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-013 Accept: start=1 while ready=1 SHALL capture a and b, clear the accumulator and step counter, and move to RUN on the next edge.
REQ-014 In RUN, each cycle k (0..N-1) SHALL add (b_reg[k] ? a_reg : 0) to the upper M bits of the accumulator through one M-bit ripple-carry adder.
REQ-015 In the same cycle, the {carry-out, sum} result SHALL be shifted right by one into the (M+N)-bit accumulator. Only one adder is used; no array of adders.
REQ-016 After step N-1 the FSM SHALL move to DONE, and prod SHALL load the final accumulator on that same edge.
REQ-017 Latency: start accepted at edge t gives done=1 during the cycle after edge t+N+1 (N RUN cycles and 1 DONE cycle).
REQ-018 DONE SHALL last exactly one cycle, then return to IDLE unless start=1.
REQ-019 Back-to-back: start=1 during DONE SHALL be accepted and SHALL go directly to RUN with no IDLE cycle.
REQ-020 start during RUN SHALL be ignored, and a and b changes during RUN SHALL have no effect on the result.
REQ-021 prod SHALL hold its last value from DONE through IDLE and the following RUN, and SHALL change only on the DONE-entry edge.
REQ-022 Arithmetic SHALL be exact for all inputs; the maximum result (2^M-1)*(2^N-1) SHALL fit in M+N bits without overflow.

Reset
REQ-023 rst_n=0 at a rising edge SHALL force: state IDLE, prod=0, accumulator=0, counter=0, done=0, busy=0, ready=1.
REQ-024 Reset asserted during RUN or DONE SHALL abort the operation with no done pulse; the aborted result SHALL never appear on prod.
REQ-025 start while rst_n=0 SHALL be ignored.

Configuration
REQ-026 Macro MULT_SEQ_ZERO_SKIP_EN, when defined: an accepted start with a==0 or b==0 SHALL go directly to DONE with prod=0, giving a 2-cycle latency to done.
REQ-027 Without MULT_SEQ_ZERO_SKIP_EN, every operation SHALL take the full N RUN cycles, including zero operands.

Structure
REQ-028 Package mult_seq_pkg SHALL hold the state enum typedef (IDLE/RUN/DONE) and default width constants M_DEF=4 and N_DEF=4.
REQ-029 The adder SHALL be one instance of the existing rca_nbit sub-module, width M, with cin tied to 0 and co used as the shifted-in MSB.
REQ-030 The step counter SHALL be $clog2(N+1) bits wide.

Verification
REQ-031 M=N=4, a=15, b=15, start for 1 cycle -> busy for 4 cycles, then done pulse with prod=225.
REQ-032 a=9, b=6, then start held high continuously -> the second operation starts in the cycle after DONE; prod=54 on both done pulses; done spacing of 5 cycles.
REQ-033 During RUN of a=3, b=5, drive start=1, a=15, b=15 -> no effect; prod=15 at done.
REQ-034 rst_n=0 for 1 cycle at RUN step 2 of a=7, b=7 -> IDLE, prod=0, no done pulse; next a=2, b=3 gives prod=6.
REQ-035 a=0, b=13 -> prod=0; done 2 cycles after accept with MULT_SEQ_ZERO_SKIP_EN, 5 cycles without it.
REQ-036 Exhaustive sweep, M=N=4: all 256 operand pairs -> prod == a*b for every pair, checked against a reference model.
